// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the Math Accelerator Unit scheduler.
//   instr_t       - one received instruction {op, a1, a2, b1, b2}
//   alu_ctrl_t    - opcode flags latched when an instruction issues
//   sched_state_t - scheduler FSM states
package mau_pkg;

    localparam int ACC_EN_BIT    = 7;
    localparam int ACC_FLUSH_BIT = 6;
    localparam int RES_W         = 18;
    localparam int VAL_W         = RES_W + 1;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] b1;
        logic [7:0] b2;
    } instr_t;

    typedef struct packed {
        logic acc_en;
        logic acc_flush;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } sched_state_t;

    // FLUSH only means anything together with ACC_EN, so it is masked here
    // and the FSM can test acc_flush on its own.
    function automatic alu_ctrl_t decode_flags(input logic [7:0] op);
        alu_ctrl_t c;
        c.acc_en    = op[ACC_EN_BIT];
        c.acc_flush = op[ACC_EN_BIT] & op[ACC_FLUSH_BIT];
        return c;
    endfunction

endpackage

// File: rtl/mau_instr_fifo.sv
// mau_instr_fifo: DEPTH x instr_t synchronous FIFO, asynchronous active-low reset.
//   push/wr_data - write request and data (ignored while full, even with a pop)
//   pop          - read request (ignored while empty)
//   rd_data      - head entry, valid while !empty
//   full/empty   - registered-count status flags
module mau_instr_fifo
    import mau_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  instr_t wr_data,
    input  logic   pop,
    output instr_t rd_data,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    instr_t        mem_q [DEPTH];
    instr_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO refuses the push even if a pop frees a slot this cycle,
    // which keeps in_ready a pure function of the count register.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mau_sched.sv
// mau_sched: in-order instruction scheduler and accumulator controller.
// Buffers received instructions, issues one at a time to decode, waits for
// its ALU result, then forwards it to TX or folds it into the accumulator.
//   in_*   - RX instruction stream (valid/ready, five 8-bit fields)
//   dec_*  - issued instruction to decode (dec_op[7:6] forced to 0)
//   alu_*  - ALU result handshake (18-bit result + carry)
//   tx_*   - result to TX (18-bit data + carry / accumulator bit 18)
//   busy   - FIFO non-empty or FSM not idle
//   acc_ovf- sticky accumulator overflow, cleared when a flush beat completes
//
// state | meaning
// IDLE  | head of FIFO offered to decode; issue on handshake
// WAIT  | one instruction in flight, waiting for its ALU result
// EMIT  | out_q presented to TX until tx_ready
module mau_sched
    import mau_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ACC_W = 19
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_op,
    input  logic [7:0]  in_a1,
    input  logic [7:0]  in_a2,
    input  logic [7:0]  in_b1,
    input  logic [7:0]  in_b2,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [7:0]  dec_op,
    output logic [7:0]  dec_a1,
    output logic [7:0]  dec_a2,
    output logic [7:0]  dec_b1,
    output logic [7:0]  dec_b2,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [17:0] alu_res,
    input  logic        alu_carry,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [17:0] tx_data,
    output logic        tx_carry,
    output logic        busy,
    output logic        acc_ovf
);

    sched_state_t     state_q, state_d;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [VAL_W-1:0] out_q, out_d;
    logic             acc_ovf_q, acc_ovf_d;

    instr_t           wr_instr;
    instr_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;

    logic [ACC_W-1:0] v_ext;
    logic [ACC_W:0]   sum;
    logic             ovf_set;
    logic             ovf_clr;

    assign wr_instr = '{op: in_op, a1: in_a1, a2: in_a2, b1: in_b1, b2: in_b2};

    mau_instr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (in_valid),
        .wr_data (wr_instr),
        .pop     (issue),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign dec_valid = (state_q == IDLE) && !fifo_empty;
    assign issue     = dec_valid && dec_ready;

    // Flag bits are consumed here and never reach decode.
    assign dec_op = {2'b00, head.op[5:0]};
    assign dec_a1 = head.a1;
    assign dec_a2 = head.a2;
    assign dec_b1 = head.b1;
    assign dec_b2 = head.b2;

    assign alu_ready = (state_q == WAIT);
    assign tx_valid  = (state_q == EMIT);
    assign tx_data   = out_q[RES_W-1:0];
    assign tx_carry  = out_q[RES_W];
    assign busy      = !fifo_empty || (state_q != IDLE);
    assign acc_ovf   = acc_ovf_q;

    assign v_ext = ACC_W'({alu_carry, alu_res});
    assign sum   = {1'b0, acc_q} + {1'b0, v_ext};

    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        acc_d   = acc_q;
        out_d   = out_q;
        ovf_set = 1'b0;
        ovf_clr = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    ctrl_d  = decode_flags(head.op);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (alu_valid) begin
                    if (!ctrl_q.acc_en) begin
                        out_d   = {alu_carry, alu_res};
                        state_d = EMIT;
                    end else begin
                        ovf_set = sum[ACC_W];
                        if (ctrl_q.acc_flush) begin
                            out_d   = sum[VAL_W-1:0];
                            acc_d   = '0;
                            state_d = EMIT;
                        end else begin
                            acc_d   = sum[ACC_W-1:0];
                            state_d = IDLE;
                        end
                    end
                end
            end
            EMIT: begin
                if (tx_ready) begin
                    ovf_clr = ctrl_q.acc_flush;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A new overflow wins over a flush clear landing in the same cycle.
        if (ovf_set) begin
            acc_ovf_d = 1'b1;
        end else if (ovf_clr) begin
            acc_ovf_d = 1'b0;
        end else begin
            acc_ovf_d = acc_ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            acc_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            acc_ovf_q <= acc_ovf_d;
        end
    end

endmodule

// File: doc/mau_sched.md
# mau_sched

In-order instruction scheduler and accumulator controller for the Math Accelerator Unit. It sits between the SPI receive stage and the decode stage, and between the ALU stage and the SPI transmit stage. It buffers up to DEPTH received 40-bit instructions, issues them one at a time, and waits for each ALU result before issuing the next. It either forwards each result to TX or folds it into a running accumulator, as selected by opcode flag bits.

## Interface
- DEPTH, 4, instruction FIFO entries; power of two, ≥2
- ACC_W, 19, accumulator width in bits; must be ≥19
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  RX instruction valid
- in_ready  out  1  space available in the FIFO
- in_op, in_a1, in_a2, in_b1, in_b2  in  8 each  received instruction fields
- dec_valid  out  1  instruction presented to decode
- dec_ready  in  1  decode can accept (decode's alu_ready)
- dec_op, dec_a1, dec_a2, dec_b1, dec_b2  out  8 each  issued instruction; dec_op[7:6] always 0
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  scheduler accepts the ALU result
- alu_res  in  18  ALU result
- alu_carry  in  1  ALU carry
- tx_valid  out  1  result available for TX
- tx_ready  in  1  TX accepts the result
- tx_data  out  18  result to TX
- tx_carry  out  1  carry or accumulator bit 18 to TX
- busy  out  1  FIFO non-empty or state ≠ IDLE
- acc_ovf  out  1  sticky accumulator overflow

## Operation
- Opcode flags:
  - op[7] = ACC_EN: the result is accumulated instead of being forwarded.
  - op[6] = ACC_FLUSH: honoured only when ACC_EN=1. After accumulating, the accumulator value is emitted to TX and then cleared.
  - Bits [5:0] pass to decode unchanged.
- FIFO: push on in_valid&&in_ready. in_ready = !full; a full FIFO does not accept a push even if a pop occurs in the same cycle. Pop on dec_valid&&dec_ready. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: dec_valid = !empty, driven from the FIFO head. On handshake, latch flags[7:6], pop the entry, go to WAIT.
  - WAIT: alu_ready=1. On alu_valid, compute v = {alu_carry, alu_res}, 19 bits, zero-extended to ACC_W.
    - ACC_EN=0: out_reg ← v, go to EMIT.
    - ACC_EN=1, FLUSH=0: acc ← acc+v, go to IDLE.
    - ACC_EN=1, FLUSH=1: out_reg ← acc+v, acc ← 0, go to EMIT.
  - EMIT: tx_valid=1, tx_data=out_reg[17:0], tx_carry=out_reg[18]. On tx_ready, go to IDLE. If the emitted value came from a flush, clear acc_ovf in the same cycle.
- Overflow: if acc+v carries out of ACC_W bits, the sum wraps modulo 2^ACC_W and acc_ovf is set. The set takes priority over the flush clear.
- At most one instruction is in flight. No new issue occurs in WAIT or EMIT.
- alu_valid outside WAIT is ignored, because alu_ready=0 there.

## Timing
- Reset values:
  - in_ready=1.
  - dec_valid, alu_ready, tx_valid, busy, acc_ovf = 0.
  - dec_* fields, tx_data, tx_carry = 0.
  - acc=0, FIFO empty, state IDLE.
- Asserting rst_n mid-operation discards all FIFO contents, any in-flight result and the accumulator immediately.
- Latency:
  - A push into an empty FIFO in cycle t gives dec_valid in cycle t+1.
  - An ALU result accepted in cycle r gives tx_valid in cycle r+1.
- All outputs are registered or decoded from state and FIFO registers; there is no combinational path from inputs to outputs.
- dec_* fields stay stable while dec_valid=1 && !dec_ready. The tx_* fields stay stable while tx_valid=1 && !tx_ready.
- A push and an issue-pop in the same cycle with the FIFO neither full nor empty both take effect, and the count is unchanged.

## Structure
- mau_pkg holds:
  - alu_ctrl_t
  - instr_t, a packed struct {op, a1, a2, b1, b2}
  - sched_state_t (IDLE, WAIT, EMIT)
  - localparams ACC_EN_BIT=7 and ACC_FLUSH_BIT=6
- Sub-module mau_instr_fifo: parameterised DEPTH × instr_t synchronous FIFO with full/empty outputs and asynchronous reset. The scheduler FSM and the accumulator live in mau_sched.

## Test plan
- Pass-through: push op=0x01, a1=3, b1=4 → dec_valid the next cycle with dec_op=0x01. Then drive alu_res=7, carry=0 → tx_data=7, tx_carry=0 one cycle after the result handshake.
- Accumulate and flush: push three instructions with op=0x81 and ALU results 100, 200, 300, then op=0xC1 with result 400 → exactly one TX beat, tx_data=1000. Afterwards acc=0 and dec_op is always 0x01.
- Full and backpressure: hold dec_ready=0 and push 5 instructions → in_ready=0 after the 4th push and the 5th is not accepted. Releasing dec_ready issues the entries in order.
- Overflow: accumulate 0x3FFFF with carry=1 four times with ACC_W=19, then flush → the emitted value is the sum modulo 2^19. acc_ovf=1 until the flush beat completes, then 0.
- TX stall: hold tx_ready=0 for 10 cycles during EMIT → tx_data stays constant, no dec_valid is asserted and alu_ready=0. The FIFO still accepts pushes.
- Reset mid-WAIT: with 2 entries queued and one in flight, pulse rst_n low → all outputs go to reset values asynchronously. A subsequent alu_valid produces no TX beat.
